gated_event_counter: RTL and testbench
======================================

Name: gated_event_counter

Overview:
Parametrised multi-channel successor to the single free-running counter. It counts enable pulses on NCH independent channels over a programmable gate window of clk cycles. At the end of each window it snapshots all channel counts into a capture register and offers them on a valid/ready handshake. Intended for frequency/rate measurement, feeding the LED/readout logic or a host register interface.

Parameters:
WIDTH, 32, bits per channel counter and per captured count
NCH, 4, number of independent channels
GATE_W, 27, width of gate length input (max window 2^GATE_W-1 cycles)
SATURATE, 1, 1 = counters saturate at all-ones; 0 = counters wrap to 0
SEQ_W, 8, width of window sequence number

Ports:
clk  in  1  single clock, all logic posedge
reset  in  1  synchronous, active-high; clears all state
ena  in  NCH  per-channel count enable, sampled every cycle in COUNT
run  in  1  level; 1 = measure continuously, 0 = stop/abort
gate_len  in  GATE_W  window length in cycles, latched at window start
busy  out  1  1 while in COUNT
cap_valid  out  1  capture register holds unread result
cap_ready  in  1  consumer accepts result when cap_valid&&cap_ready
cap_data  out  NCH*WIDTH  channel i count in bits [i*WIDTH +: WIDTH]
cap_ovf  out  NCH  per-channel overflow during captured window
cap_seq  out  SEQ_W  sequence number of captured window
dropped  out  1  sticky: a completed window was discarded

Behaviour:
- Reset: state IDLE; busy, cap_valid, cap_data, cap_ovf, cap_seq, dropped, all channel counters, ovf flags, gate counter and seq counter = 0.
- FSM states IDLE, COUNT.
- IDLE: if run=1, latch L = (gate_len==0 ? 1 : gate_len), clear counters and ovf flags, go to COUNT next edge. Otherwise stay.
- COUNT: window = exactly L consecutive COUNT cycles. Each cycle, ena[i]=1 increments cnt[i].
- Overflow: ena[i] with cnt[i]==all-ones sets ovf[i]. SATURATE=1 holds cnt at all-ones; SATURATE=0 wraps to 0.
- Last window cycle (gate counter == 1): capture value = cnt[i] including that cycle's ena[i] (same saturate/wrap rule), and ovf[i] including that cycle. Seq counter increments by 1, wraps at 2^SEQ_W, and counts dropped windows too.
  - run=1: counters and ovf clear, L re-latched from gate_len, next window starts immediately. No dead cycle.
  - run=0: go to IDLE.
- run=0 in any non-final COUNT cycle: abort; no capture, seq unchanged, IDLE next edge.
- Capture handshake:
  - A completed window loads cap_data/cap_ovf/cap_seq and sets cap_valid=1 on the same edge that ends the window.
  - cap_valid && cap_ready clears cap_valid next edge, unless a new capture lands on that same edge; then the new result loads and cap_valid stays 1.
  - New capture while cap_valid=1 and cap_ready=0: new result discarded, held result unchanged, dropped set to 1. dropped clears only on reset.
  - cap_* outputs stable while cap_valid=1 and not accepted.
- Latency: result visible on cap_data the cycle after the final window cycle's edge.
- busy = (state==COUNT), registered.
- Mid-operation reset: next edge returns to the reset state regardless of handshake.

Decomposition:
- Package gec_pkg: state enum (IDLE, COUNT), localparam CNT_MAX = all-ones helper, SATURATE encoding constants.
- Sub-module gec_channel: one WIDTH-bit counter with clear, ena, saturate/wrap and sticky ovf. It also provides a combinational next-value output used for capture. Instantiated NCH times via generate.
- Top holds FSM, gate down-counter, seq counter and capture/handshake register.

Test Plan:
- NCH=4, gate_len=10, run=1, ena=4'b1111 constant, cap_ready=1 -> cap_data = 10 on all channels every 10 cycles, cap_seq 0,1,2..., cap_ovf=0, dropped=0.
- ena[0] pulses every 3rd cycle, gate_len=9 -> ch0 = 3; ena[1]=0 -> ch1 = 0. Windows back-to-back with no event lost across the boundary (toggle pattern spanning the edge, sum of two windows = total pulses).
- WIDTH=4, gate_len=20, ena[0]=1: SATURATE=1 -> count 15, cap_ovf[0]=1; SATURATE=0 -> count 4, cap_ovf[0]=1.
- cap_ready=0 for 3 windows, gate_len=5 -> first result (seq 0) held unchanged, dropped=1. Raise cap_ready on the 4th window's final edge -> seq 3 loaded, cap_valid stays 1.
- run dropped at cycle 4 of a 10-cycle window -> no capture, cap_seq unchanged, busy=0 next cycle. gate_len=0 -> 1-cycle windows, count = ena each cycle.
- reset asserted mid-window with cap_valid=1 -> next cycle all outputs 0, state IDLE. Restart with run=1 -> seq restarts at 0.

Source files
------------

// File: rtl/gated_event_counter_pkg.sv
// Shared types and constants for the gated multi-channel event counter.
package gec_pkg;

  // Measurement FSM: idle, or counting inside a gate window.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } gec_state_t;

  // Encodings for the counter overflow policy.
  localparam bit SAT_WRAP = 1'b0;
  localparam bit SAT_HOLD = 1'b1;

  // Widest counter the all-ones helper can describe.
  localparam int CNT_MAX_W = 64;

  // All-ones value for a counter of the given width, right-aligned.
  function automatic logic [CNT_MAX_W-1:0] cnt_max(input int unsigned width);
    cnt_max = {CNT_MAX_W{1'b1}} >> (CNT_MAX_W - width);
  endfunction

endpackage

// File: rtl/gated_event_counter_channel.sv
// One event-counting channel: WIDTH-bit counter with saturate/wrap and a
// sticky overflow flag. The combinational next value is exported so the top
// can capture a window total that includes the final cycle's event.
module gec_channel
  import gec_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit SATURATE = SAT_HOLD
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_count,
  input  logic             i_ena,
  output logic [WIDTH-1:0] o_cnt_nxt,
  output logic             o_ovf_nxt
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(cnt_max(WIDTH));

  logic [WIDTH-1:0] r_cnt;
  logic             r_ovf;
  logic             w_hit;

  assign w_hit = i_count & i_ena;

  // Next count and overflow value for this cycle's enable.
  always_comb begin
    o_cnt_nxt = r_cnt;
    o_ovf_nxt = r_ovf;
    if (w_hit) begin
      if (r_cnt == CNT_MAX) begin
        o_ovf_nxt = 1'b1;
        if (SATURATE == SAT_HOLD) begin
          o_cnt_nxt = CNT_MAX;
        end else begin
          o_cnt_nxt = '0;
        end
      end else begin
        o_cnt_nxt = r_cnt + WIDTH'(1'b1);
      end
    end else begin
      o_cnt_nxt = r_cnt;
    end
  end

  // Counter state; a window start clears it ahead of any increment.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_cnt <= o_cnt_nxt;
      r_ovf <= o_ovf_nxt;
    end
  end

endmodule

// File: rtl/gated_event_counter.sv
// Multi-channel gated event counter: counts per-channel enables over a
// programmable window, captures all totals at the end of each window and
// offers them on a valid/ready handshake with drop detection.
module gated_event_counter
  import gec_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NCH      = 4,
  parameter int GATE_W   = 27,
  parameter bit SATURATE = 1'b1,
  parameter int SEQ_W    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NCH-1:0]       i_ena,
  input  logic                 i_run,
  input  logic [GATE_W-1:0]    i_gate_len,
  output logic                 o_busy,
  output logic                 o_cap_valid,
  input  logic                 i_cap_ready,
  output logic [NCH*WIDTH-1:0] o_cap_data,
  output logic [NCH-1:0]       o_cap_ovf,
  output logic [SEQ_W-1:0]     o_cap_seq,
  output logic                 o_dropped
);

  gec_state_t           r_state, w_state_nxt;
  logic [GATE_W-1:0]    r_gate, w_gate_nxt, w_len;
  logic [SEQ_W-1:0]     r_seq;
  logic                 w_count, w_final, w_clear;
  logic [NCH*WIDTH-1:0] w_cnt_nxt;
  logic [NCH-1:0]       w_ovf_nxt;
  logic                 r_busy, r_cap_valid, r_dropped;
  logic [NCH*WIDTH-1:0] r_cap_data;
  logic [NCH-1:0]       r_cap_ovf;
  logic [SEQ_W-1:0]     r_cap_seq;

  // A zero length degenerates to a single-cycle window.
  assign w_len   = (i_gate_len == '0) ? GATE_W'(1) : i_gate_len;
  assign w_count = (r_state == ST_COUNT);
  assign w_final = w_count && (r_gate == GATE_W'(1));

  // Next state, gate reload/decrement and window-start clear.
  always_comb begin
    w_state_nxt = r_state;
    w_gate_nxt  = r_gate;
    w_clear     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_run) begin
          w_state_nxt = ST_COUNT;
          w_gate_nxt  = w_len;
          w_clear     = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (w_final && i_run) begin
          // Back-to-back window: restart with no dead cycle.
          w_state_nxt = ST_COUNT;
          w_gate_nxt  = w_len;
          w_clear     = 1'b1;
        end else if (w_final || !i_run) begin
          // Normal end with run low, or abort mid-window.
          w_state_nxt = ST_IDLE;
          w_gate_nxt  = '0;
        end else begin
          w_gate_nxt  = r_gate - GATE_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gate_nxt  = '0;
      end
    endcase
  end

  // FSM state, gate down-counter and registered busy flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_gate  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gate  <= w_gate_nxt;
      r_busy  <= (w_state_nxt == ST_COUNT);
    end
  end

  // Channel counters.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    gec_channel #(
      .WIDTH   (WIDTH),
      .SATURATE(SATURATE)
    ) u_ch (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_clear  (w_clear),
      .i_count  (w_count),
      .i_ena    (i_ena[g]),
      .o_cnt_nxt(w_cnt_nxt[g*WIDTH +: WIDTH]),
      .o_ovf_nxt(w_ovf_nxt[g])
    );
  end

  // Sequence counter and capture register with valid/ready handshake.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_seq       <= '0;
      r_cap_valid <= 1'b0;
      r_cap_data  <= '0;
      r_cap_ovf   <= '0;
      r_cap_seq   <= '0;
      r_dropped   <= 1'b0;
    end else if (w_final) begin
      r_seq <= r_seq + SEQ_W'(1);
      if (!r_cap_valid || i_cap_ready) begin
        r_cap_data  <= w_cnt_nxt;
        r_cap_ovf   <= w_ovf_nxt;
        r_cap_seq   <= r_seq;
        r_cap_valid <= 1'b1;
      end else begin
        // Held result is still unread: discard the new one.
        r_dropped <= 1'b1;
      end
    end else if (r_cap_valid && i_cap_ready) begin
      r_cap_valid <= 1'b0;
    end
  end

  assign o_busy      = r_busy;
  assign o_cap_valid = r_cap_valid;
  assign o_cap_data  = r_cap_data;
  assign o_cap_ovf   = r_cap_ovf;
  assign o_cap_seq   = r_cap_seq;
  assign o_dropped   = r_dropped;

endmodule

// File: tb/tb_gated_event_counter.sv
// Scoreboard bench for gated_event_counter: directed stimulus pushes
// hand-computed captures into a queue; a monitor pops on each handshake.
module tb_gated_event_counter;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   ovf;
    logic [7:0]   seq;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   m_ena;
  logic         m_run, m_ready;
  logic [26:0]  m_gate;
  logic         m_busy, m_valid, m_dropped;
  logic [127:0] m_data;
  logic [3:0]   m_ovf;
  logic [7:0]   m_seq;

  logic         x_ena, x_run;
  logic [26:0]  x_gate;
  logic         s_busy, s_valid, s_ovf, s_dropped;
  logic [3:0]   s_data;
  logic [7:0]   s_seq;
  logic         w_busy, w_valid, w_ovf, w_dropped;
  logic [3:0]   w_data;
  logic [7:0]   w_seq;

  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  gated_event_counter dut (
    .i_clk(clk), .i_reset(rst), .i_ena(m_ena), .i_run(m_run), .i_gate_len(m_gate),
    .o_busy(m_busy), .o_cap_valid(m_valid), .i_cap_ready(m_ready), .o_cap_data(m_data),
    .o_cap_ovf(m_ovf), .o_cap_seq(m_seq), .o_dropped(m_dropped)
  );

  gated_event_counter #(.WIDTH(4), .NCH(1), .SATURATE(1'b1)) dut_sat (
    .i_clk(clk), .i_reset(rst), .i_ena(x_ena), .i_run(x_run), .i_gate_len(x_gate),
    .o_busy(s_busy), .o_cap_valid(s_valid), .i_cap_ready(1'b1), .o_cap_data(s_data),
    .o_cap_ovf(s_ovf), .o_cap_seq(s_seq), .o_dropped(s_dropped)
  );

  gated_event_counter #(.WIDTH(4), .NCH(1), .SATURATE(1'b0)) dut_wrap (
    .i_clk(clk), .i_reset(rst), .i_ena(x_ena), .i_run(x_run), .i_gate_len(x_gate),
    .o_busy(w_busy), .o_cap_valid(w_valid), .i_cap_ready(1'b1), .o_cap_data(w_data),
    .o_cap_ovf(w_ovf), .o_cap_seq(w_seq), .o_dropped(w_dropped)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int c0, input int c1, input int c2, input int c3, input int s);
    exp_t e;
    e.data = {32'(c3), 32'(c2), 32'(c1), 32'(c0)};
    e.ovf  = 4'b0000;
    e.seq  = 8'(s);
    exp_q.push_back(e);
  endtask

  // Per-test enable pattern; c is the edge index from the window-start edge.
  function automatic logic [3:0] pat_ena(input int pid, input int c);
    logic [3:0] e;
    e = 4'b0000;
    case (pid)
      1, 4, 5: e = 4'b1111;
      2: begin
        e[0] = (c % 3 == 0);
        e[1] = 1'b0;
        e[2] = (c >= 7 && c <= 12);
        e[3] = (c % 2 == 1);
      end
      3: e = (c <= 5) ? 4'b1111 : 4'b0011;
      6: begin
        case (c)
          1:       e = 4'b0001;
          2:       e = 4'b0110;
          3:       e = 4'b1111;
          4:       e = 4'b1000;
          default: e = 4'b0000;
        endcase
      end
      default: e = 4'b0000;
    endcase
    return e;
  endfunction

  function automatic logic pat_run(input int pid, input int c);
    case (pid)
      1:       return (c <= 30);
      2:       return (c <= 18);
      3:       return (c <= 20);
      4:       return 1'b1;
      5, 6:    return (c <= 3);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic pat_ready(input int pid, input int c);
    case (pid)
      3:       return (c >= 20);
      4:       return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [26:0] pat_gate(input int pid);
    case (pid)
      2:       return 27'd9;
      3:       return 27'd5;
      6:       return 27'd0;
      default: return 27'd10;
    endcase
  endfunction

  task automatic drive(input int pid, input int c0, input int c1);
    for (int c = c0; c <= c1; c++) begin
      m_ena   = pat_ena(pid, c);
      m_run   = pat_run(pid, c);
      m_ready = pat_ready(pid, c);
      m_gate  = pat_gate(pid);
      tick();
    end
  endtask

  task automatic stop();
    m_run   = 1'b0;
    m_ena   = 4'b0000;
    m_ready = 1'b1;
    tick();
    tick();
  endtask

  // Monitor: every accepted capture is compared with the queue head.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_capture: got seq %0d expected none", m_seq);
      end else begin
        mon_e = exp_q.pop_front();
        chk("cap_data", m_data, mon_e.data);
        chk("cap_ovf",  128'(m_ovf), 128'(mon_e.ovf));
        chk("cap_seq",  128'(m_seq), 128'(mon_e.seq));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; m_ena = 4'b0000; m_run = 1'b0; m_ready = 1'b1; m_gate = 27'd0;
    x_ena = 1'b0; x_run = 1'b0; x_gate = 27'd0;
    tick(); tick();
    chk("rst_busy",    128'(m_busy), 128'd0);
    chk("rst_valid",   128'(m_valid), 128'd0);
    chk("rst_data",    m_data, 128'd0);
    chk("rst_seq",     128'(m_seq), 128'd0);
    chk("rst_dropped", 128'(m_dropped), 128'd0);
    rst = 1'b0;
    tick();

    // Constant enables, 10-cycle windows, back-to-back.
    push_exp(10, 10, 10, 10, 0);
    push_exp(10, 10, 10, 10, 1);
    push_exp(10, 10, 10, 10, 2);
    drive(1, 0, 31);
    stop();
    chk("t1_dropped", 128'(m_dropped), 128'd0);

    // Periodic and boundary-spanning patterns, 9-cycle windows.
    push_exp(3, 0, 3, 5, 3);
    push_exp(3, 0, 3, 4, 4);
    drive(2, 0, 19);
    stop();
    chk("t2_dropped", 128'(m_dropped), 128'd0);

    // 4-bit counters driven for 20 cycles: saturate vs wrap.
    x_run = 1'b1; x_ena = 1'b1; x_gate = 27'd20;
    repeat (21) tick();
    chk("sat_valid", 128'(s_valid), 128'd1);
    chk("sat_data",  128'(s_data), 128'd15);
    chk("sat_ovf",   128'(s_ovf), 128'd1);
    chk("wrap_data", 128'(w_data), 128'd4);
    chk("wrap_ovf",  128'(w_ovf), 128'd1);
    chk("wrap_seq",  128'(w_seq), 128'd0);
    x_run = 1'b0; x_ena = 1'b0;
    tick(); tick();

    // Reset mid-window while a result is pending.
    drive(4, 0, 13);
    chk("t4_valid", 128'(m_valid), 128'd1);
    chk("t4_seq",   128'(m_seq), 128'd5);
    chk("t4_data",  m_data, {32'd10, 32'd10, 32'd10, 32'd10});
    chk("t4_busy",  128'(m_busy), 128'd1);
    m_run = 1'b0;
    rst = 1'b1;
    tick();
    chk("mrst_busy",  128'(m_busy), 128'd0);
    chk("mrst_valid", 128'(m_valid), 128'd0);
    chk("mrst_data",  m_data, 128'd0);
    chk("mrst_ovf",   128'(m_ovf), 128'd0);
    chk("mrst_seq",   128'(m_seq), 128'd0);
    rst = 1'b0;
    m_ready = 1'b1;
    tick();

    // Back-pressure: windows 1 and 2 dropped, window 3 lands on accept edge.
    push_exp(5, 5, 5, 5, 0);
    push_exp(5, 5, 0, 0, 3);
    drive(3, 0, 17);
    chk("t3_dropped", 128'(m_dropped), 128'd1);
    chk("t3_held_seq",   128'(m_seq), 128'd0);
    chk("t3_held_valid", 128'(m_valid), 128'd1);
    chk("t3_held_data",  m_data, {32'd5, 32'd5, 32'd5, 32'd5});
    drive(3, 18, 21);
    stop();
    chk("t3_valid_after", 128'(m_valid), 128'd0);
    chk("t3_dropped_sticky", 128'(m_dropped), 128'd1);

    // Abort in the 4th cycle of a 10-cycle window.
    drive(5, 0, 3);
    chk("t5_busy_run", 128'(m_busy), 128'd1);
    drive(5, 4, 4);
    chk("t5_busy_abort", 128'(m_busy), 128'd0);
    chk("t5_valid",      128'(m_valid), 128'd0);
    chk("t5_seq",        128'(m_seq), 128'd3);
    stop();

    // Zero gate length: single-cycle windows.
    push_exp(1, 0, 0, 0, 4);
    push_exp(0, 1, 1, 0, 5);
    push_exp(1, 1, 1, 1, 6);
    push_exp(0, 0, 0, 1, 7);
    drive(6, 0, 4);
    stop();
    repeat (3) tick();
    chk("queue_drained", 128'(exp_q.size()), 128'd0);
    chk("final_busy", 128'(m_busy), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
